// File: rtl/vector_issue_scheduler.sv
// Issue scheduler steering vector ops to the logic/shift units, with a writeback
// reservation table that serialises commits and blocks RAW/WAW and commit-slot conflicts.
module vector_issue_scheduler #(
  parameter int unsigned LOGIC_LATENCY = 1,
  parameter int unsigned SHIFT_LATENCY = 3,
  parameter int unsigned REG_IDX_W     = 5
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_unit,
  input  logic [REG_IDX_W-1:0] in_vd,
  input  logic [REG_IDX_W-1:0] in_vs2,
  input  logic [REG_IDX_W-1:0] in_vs1,
  input  logic                 in_uses_vs1,
  input  logic                 flush,
  output logic                 logic_issue,
  output logic                 shift_issue,
  output logic                 wb_valid,
  output logic                 wb_unit,
  output logic [REG_IDX_W-1:0] wb_vd,
  output logic                 busy,
  output logic [15:0]          stall_count
);

  localparam int unsigned MaxLat = (LOGIC_LATENCY > SHIFT_LATENCY) ? LOGIC_LATENCY
                                                                    : SHIFT_LATENCY;

  // Slot k describes the result committing k cycles from now.
  logic [MaxLat-1:0]                valid_q, valid_d;
  logic [MaxLat-1:0]                unit_q, unit_d;
  logic [MaxLat-1:0][REG_IDX_W-1:0] vd_q, vd_d;
  logic [15:0]                      stall_q, stall_d;

  logic [MaxLat-1:0] struct_vec, raw_vec, waw_vec;
  int unsigned       lat;
  logic              accept;

  assign lat = in_unit ? SHIFT_LATENCY : LOGIC_LATENCY;

  for (genvar k = 0; k < MaxLat; k++) begin : g_slot
    logic                 sh_valid;
    logic                 sh_unit;
    logic [REG_IDX_W-1:0] sh_vd;
    logic                 wr;

    // An op of latency L lands in slot L-1, which slot L would shift into.
    assign struct_vec[k] = valid_q[k] && (lat == k);
    assign raw_vec[k]    = valid_q[k] &&
                           ((vd_q[k] == in_vs2) || (in_uses_vs1 && (vd_q[k] == in_vs1)));
    assign waw_vec[k]    = valid_q[k] && (vd_q[k] == in_vd);

    if (k == MaxLat - 1) begin : g_top
      assign sh_valid = 1'b0;
      assign sh_unit  = 1'b0;
      assign sh_vd    = '0;
    end else begin : g_mid
      assign sh_valid = valid_q[k+1];
      assign sh_unit  = unit_q[k+1];
      assign sh_vd    = vd_q[k+1];
    end

    assign wr         = accept && (lat == k + 1);
    assign valid_d[k] = !flush && (wr || sh_valid);
    assign unit_d[k]  = wr ? in_unit : sh_unit;
    assign vd_d[k]    = wr ? in_vd : sh_vd;
  end

  assign in_ready    = !flush && !(|struct_vec) && !(|raw_vec) && !(|waw_vec);
  assign accept      = in_valid && in_ready;
  assign logic_issue = accept && !in_unit;
  assign shift_issue = accept && in_unit;

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      unit_q  <= '0;
      vd_q    <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      unit_q  <= unit_d;
      vd_q    <= vd_d;
      stall_q <= stall_d;
    end
  end

  assign wb_valid    = valid_q[0];
  assign wb_unit     = unit_q[0];
  assign wb_vd       = vd_q[0];
  assign busy        = |valid_q;
  assign stall_count = stall_q;

endmodule
